// File: rtl/if_stage.sv
// Instruction fetch stage: PC register, ROM fetch and IF/ID register.
// Ports: clk/rst, stall/flush/branch_flag/branch_target in, rom_ce/rom_addr
// out, rom_data in, id_pc/id_inst/id_valid to decode, halted, misalign.
module if_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          ROM_WORDS = 28
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic        branch_flag,
    input  logic [31:0] branch_target,
    output logic        rom_ce,
    output logic [4:0]  rom_addr,
    input  logic [31:0] rom_data,
    output logic [31:0] id_pc,
    output logic [31:0] id_inst,
    output logic        id_valid,
    output logic        halted,
    output logic        misalign
);

    localparam logic [29:0] ROM_LIMIT = 30'(ROM_WORDS);

    logic [31:0] pc_q, pc_d;
    logic        rom_ce_q, rom_ce_d;
    logic        misalign_q, misalign_d;
    logic [31:0] id_pc_q, id_pc_d;
    logic [31:0] id_inst_q, id_inst_d;
    logic        id_valid_q, id_valid_d;
    logic        halt_w;
    logic        fetch_ok;
    logic [31:0] fetch_inst;

    // Halt is a pure function of the live PC so the PC parks on the first
    // out-of-range address instead of overshooting it by one word.
    assign halt_w   = rom_ce_q && (pc_q[31:2] >= ROM_LIMIT);
    assign fetch_ok = rom_ce_q && !halt_w;

    // ROM stores words byte-reversed; swap back to MIPS order.
    assign fetch_inst = fetch_ok ?
        {rom_data[7:0], rom_data[15:8], rom_data[23:16], rom_data[31:24]} :
        32'h0;

    always_comb begin
        pc_d       = pc_q;
        rom_ce_d   = 1'b1;
        misalign_d = branch_flag && (branch_target[1:0] != 2'b00);
        if (rom_ce_q) begin
            if (branch_flag) begin
                pc_d = {branch_target[31:2], 2'b00};
            end else if (stall) begin
                pc_d = pc_q;
            end else if (halt_w) begin
                pc_d = pc_q;
            end else begin
                pc_d = pc_q + 32'd4;
            end
        end
    end

    always_comb begin
        id_pc_d    = id_pc_q;
        id_inst_d  = id_inst_q;
        id_valid_d = id_valid_q;
        if (flush) begin
            id_pc_d    = 32'h0;
            id_inst_d  = 32'h0;
            id_valid_d = 1'b0;
        end else if (!stall) begin
            id_pc_d    = pc_q;
            id_inst_d  = fetch_inst;
            id_valid_d = fetch_ok;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            rom_ce_q   <= 1'b0;
            misalign_q <= 1'b0;
            id_pc_q    <= 32'h0;
            id_inst_q  <= 32'h0;
            id_valid_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            rom_ce_q   <= rom_ce_d;
            misalign_q <= misalign_d;
            id_pc_q    <= id_pc_d;
            id_inst_q  <= id_inst_d;
            id_valid_q <= id_valid_d;
        end
    end

    assign rom_ce   = rom_ce_q;
    assign rom_addr = pc_q[6:2];
    assign id_pc    = id_pc_q;
    assign id_inst  = id_inst_q;
    assign id_valid = id_valid_q;
    assign halted   = halt_w;
    assign misalign = misalign_q;

endmodule

// File: tb/tb_if_stage.sv
// Directed testbench for if_stage.
// ROM word i holds 32'h112233ii (word 0 holds 32'hff000134).
module tb_if_stage;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        flush;
    logic        branch_flag;
    logic [31:0] branch_target;
    logic        rom_ce;
    logic [4:0]  rom_addr;
    logic [31:0] rom_data;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic        id_valid;
    logic        halted;
    logic        misalign;

    logic [31:0] rom [32];
    int          total;
    int          bad;

    if_stage #(
        .RESET_PC (32'h0000_0000),
        .ROM_WORDS(28)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .flush        (flush),
        .branch_flag  (branch_flag),
        .branch_target(branch_target),
        .rom_ce       (rom_ce),
        .rom_addr     (rom_addr),
        .rom_data     (rom_data),
        .id_pc        (id_pc),
        .id_inst      (id_inst),
        .id_valid     (id_valid),
        .halted       (halted),
        .misalign     (misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign rom_data = rom[rom_addr];

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        for (int i = 0; i < 32; i++) rom[i] = 32'h1122_3300 + 32'(i);
        rom[0] = 32'hff00_0134;

        rst = 1'b1; stall = 1'b0; flush = 1'b0;
        branch_flag = 1'b0; branch_target = 32'h0;
        tick(3);
        check("rst_ce",   32'(rom_ce),   32'h0);
        check("rst_addr", 32'(rom_addr), 32'h0);
        check("rst_pc",   id_pc,         32'h0);
        check("rst_inst", id_inst,       32'h0);
        check("rst_vld",  32'(id_valid), 32'h0);
        check("rst_halt", 32'(halted),   32'h0);
        check("rst_mis",  32'(misalign), 32'h0);

        // Release: edge 1 enables fetch, edge 2 loads IF/ID.
        rst = 1'b0;
        tick(1);
        check("e1_ce",   32'(rom_ce),   32'h1);
        check("e1_addr", 32'(rom_addr), 32'h0);
        check("e1_vld",  32'(id_valid), 32'h0);
        tick(1);
        check("e2_pc",   id_pc,         32'h0);
        check("e2_inst", id_inst,       32'h3401_00ff);
        check("e2_vld",  32'(id_valid), 32'h1);
        check("e2_addr", 32'(rom_addr), 32'h1);

        // Advance to pc=0x10, then stall three cycles.
        tick(3);
        check("pre_addr", 32'(rom_addr), 32'h4);
        check("pre_inst", id_inst,       32'h0333_2211);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            check("stl_addr", 32'(rom_addr), 32'h4);
            check("stl_pc",   id_pc,         32'h0000_000c);
            check("stl_inst", id_inst,       32'h0333_2211);
        end
        stall = 1'b0;
        tick(1);
        check("rel_addr", 32'(rom_addr), 32'h5);
        check("rel_pc",   id_pc,         32'h0000_0010);
        check("rel_inst", id_inst,       32'h0433_2211);

        // Branch under stall wins for the PC; IF/ID holds.
        stall = 1'b1; branch_flag = 1'b1; branch_target = 32'h20;
        tick(1);
        check("bs_addr", 32'(rom_addr), 32'h8);
        check("bs_mis",  32'(misalign), 32'h0);
        check("bs_pc",   id_pc,         32'h0000_0010);
        stall = 1'b0; branch_flag = 1'b0;

        // Misaligned branch target 0x22 -> pc 0x20.
        branch_flag = 1'b1; branch_target = 32'h22;
        tick(1);
        check("ma_addr", 32'(rom_addr), 32'h8);
        check("ma_mis",  32'(misalign), 32'h1);
        check("ma_pc",   id_pc,         32'h0000_0020);
        check("ma_inst", id_inst,       32'h0833_2211);
        branch_flag = 1'b0;
        tick(1);
        check("ma_mis0", 32'(misalign), 32'h0);
        check("ma_next", 32'(rom_addr), 32'h9);

        // Flush with stall: entry killed, PC held.
        flush = 1'b1; stall = 1'b1;
        tick(1);
        check("fs_vld",  32'(id_valid), 32'h0);
        check("fs_inst", id_inst,       32'h0);
        check("fs_pc",   id_pc,         32'h0);
        check("fs_addr", 32'(rom_addr), 32'h9);
        flush = 1'b0; stall = 1'b0;

        // Free-run from 0x24 to 0x70 (19 steps) and halt there.
        tick(18);
        check("h_pre",     32'(halted),   32'h0);
        check("h_preaddr", 32'(rom_addr), 32'd27);
        tick(1);
        check("h_set",  32'(halted),   32'h1);
        check("h_addr", 32'(rom_addr), 32'd28);
        check("h_pc6c", id_pc,         32'h0000_006c);
        check("h_vld1", 32'(id_valid), 32'h1);
        tick(2);
        check("h_hold", 32'(rom_addr), 32'd28);
        check("h_vld",  32'(id_valid), 32'h0);
        check("h_inst", id_inst,       32'h0);
        check("h_pc",   id_pc,         32'h0000_0070);
        check("h_ce",   32'(rom_ce),   32'h1);

        // Branch back to 0 clears halt.
        branch_flag = 1'b1; branch_target = 32'h0;
        tick(1);
        check("hb_halt", 32'(halted),   32'h0);
        check("hb_addr", 32'(rom_addr), 32'h0);
        branch_flag = 1'b0;
        tick(1);
        check("hb_pc",   id_pc,         32'h0);
        check("hb_inst", id_inst,       32'h3401_00ff);
        check("hb_vld",  32'(id_valid), 32'h1);

        // Reset mid-stall/branch discards the pending update.
        stall = 1'b1; branch_flag = 1'b1; branch_target = 32'h40;
        #2 rst = 1'b1;
        #1;
        check("ar_ce",   32'(rom_ce),   32'h0);
        check("ar_addr", 32'(rom_addr), 32'h0);
        check("ar_vld",  32'(id_valid), 32'h0);
        check("ar_inst", id_inst,       32'h0);
        @(negedge clk);
        tick(1);
        stall = 1'b0; branch_flag = 1'b0;
        rst = 1'b0;
        tick(2);
        check("rr_pc",   id_pc,         32'h0);
        check("rr_inst", id_inst,       32'h3401_00ff);
        check("rr_vld",  32'(id_valid), 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, byte address fetched first after reset.
REQ-002 SHALL have parameter ROM_WORDS, default 28, number of valid instruction words in the attached ROM.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port stall  input  1  hold PC and IF/ID register.
REQ-006 SHALL have port flush  input  1  kill the IF/ID entry.
REQ-007 SHALL have port branch_flag  input  1  redirect PC to branch_target.
REQ-008 SHALL have port branch_target  input  32  redirect byte address.
REQ-009 SHALL have port rom_ce  output  1  ROM fetch enable.
REQ-010 SHALL have port rom_addr  output  5  ROM word address.
REQ-011 SHALL have port rom_data  input  32  ROM word, byte-reversed storage.
REQ-012 SHALL have port id_pc  output  32  PC of the instruction held for decode.
REQ-013 SHALL have port id_inst  output  32  instruction held for decode, MIPS byte order.
REQ-014 SHALL have port id_valid  output  1  id_inst is a real fetched instruction.
REQ-015 SHALL have port halted  output  1  PC has run past ROM_WORDS.
REQ-016 SHALL have port misalign  output  1  one-cycle pulse, branch target not word-aligned.

Function
REQ-017 SHALL drive rom_addr = pc[6:2] combinationally from the internal PC register.
REQ-018 SHALL deassert rom_ce during reset and set it to 1 on the first rising edge after rst falls, with PC held at RESET_PC on that edge.
REQ-019 SHALL form the fetched instruction as {rom_data[7:0], rom_data[15:8], rom_data[23:16], rom_data[31:24]} when rom_ce=1 and not halted, else 32'h0.
REQ-020 SHALL apply PC update priority per edge (rom_ce=1): branch_flag > stall > halted > increment.
REQ-021 SHALL load PC with {branch_target[31:2], 2'b00} when branch_flag=1, regardless of stall, and clear halted.
REQ-022 SHALL pulse misalign for exactly one cycle when branch_flag=1 and branch_target[1:0] != 0.
REQ-023 SHALL hold PC when stall=1 and branch_flag=0.
REQ-024 SHALL otherwise increment PC by 4 modulo 2^32.
REQ-025 SHALL set halted when the word index pc[31:2] >= ROM_WORDS and then hold PC until branch or reset.
REQ-026 SHALL update IF/ID with priority flush > stall > load.
REQ-027 SHALL, on flush, set id_pc=0, id_inst=0 and id_valid=0, even when stall=1.
REQ-028 SHALL, on stall without flush, hold id_pc, id_inst and id_valid.
REQ-029 SHALL, on load, capture id_pc=pc, id_inst=fetched instruction, and id_valid=rom_ce & ~halted.
REQ-030 SHALL produce a one-cycle latency from PC presentation to id_inst.
REQ-031 SHALL make a branch and a flush on the same edge take effect together: PC redirects and the IF/ID entry is killed.

Reset
REQ-032 SHALL, while rst=1, force pc=RESET_PC, rom_ce=0, id_pc=0, id_inst=0, id_valid=0, halted=0 and misalign=0 asynchronously.
REQ-033 SHALL, when rst asserts mid-stall or mid-branch, discard any pending update; fetch restarts from RESET_PC per REQ-018.

Verification
REQ-034 SHALL cover reset release with rom_data=32'hff000134 at pc 0: two edges later id_pc=0, id_inst=32'h340100ff, id_valid=1.
REQ-035 SHALL cover stall=1 for 3 cycles at pc=0x10: rom_addr stays 4 and id_pc/id_inst unchanged; after release, pc advances to 0x14.
REQ-036 SHALL cover branch_flag=1 with target 0x20 while stall=1: next cycle rom_addr=8, misalign=0.
REQ-037 SHALL cover branch_flag=1 with target 0x22: pc=0x20, misalign high exactly one cycle.
REQ-038 SHALL cover free-run to pc=0x70 with ROM_WORDS=28: halted=1, pc holds 0x70, id_valid=0, id_inst=0; branch to 0x0 clears halted.
REQ-039 SHALL cover flush=1 and stall=1 on the same edge: id_valid=0, id_inst=0, and PC holds.
